// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority; a saturating starvation counter forces fetch to win after MAX_WAIT losses.
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        clr,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t      state_r;
    owner_t      owner_r;
    logic [3:0]  starveCnt_r;
    logic        err_r;

    logic        idle_s;
    logic        selD_s;
    logic        selI_s;
    logic        accept_s;

    // Arbitration, memory request mux, grants and response routing.
    always_comb begin
        idle_s   = (state_r == ST_IDLE);
        selD_s   = d_req && !(i_req && (starveCnt_r == MAX_WAIT_C));
        selI_s   = i_req && !selD_s;
        mem_req  = idle_s && (i_req || d_req);
        accept_s = mem_req && mem_gnt;
        i_gnt    = accept_s && selI_s;
        d_gnt    = accept_s && selD_s;

        if (selD_s) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = i_addr;
            mem_wdata = 32'd0;
            mem_be    = 4'b1111;
        end

        i_rvalid = !idle_s && mem_rvalid && (owner_r == OWN_I);
        d_rvalid = !idle_s && mem_rvalid && (owner_r == OWN_D);
        i_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
        err      = err_r;
    end

    // Transaction FSM, owner tracking, fetch starvation counter and sticky error flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_I;
            starveCnt_r <= 4'd0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A response with nothing outstanding is dropped and flagged.
                    if (mem_rvalid) begin
                        err_r <= 1'b1;
                    end
                    if (accept_s) begin
                        state_r <= ST_BUSY;
                        owner_r <= selD_s ? OWN_D : OWN_I;
                    end
                end
                ST_BUSY: begin
                    if (mem_rvalid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (!i_req || i_gnt) begin
                starveCnt_r <= 4'd0;
            end else if (d_gnt && (starveCnt_r != MAX_WAIT_C)) begin
                starveCnt_r <= starveCnt_r + 4'd1;
            end
        end
    end

endmodule
